// File: rtl/sound_dac_sched.sv
// Stereo sample scheduler for the sound_dac serializer. It keeps one small FIFO per channel
// and, on each load strobe, registers the next word for the opposite channel.
module sound_dac_sched #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        load,
    input  logic        dac_leftright,
    input  logic        wr_stb,
    input  logic        wr_right,
    input  logic [15:0] wr_data,
    input  logic        mute,
    input  logic        hold_last,
    input  logic        cnt_clr,
    output logic [15:0] dac_datain,
    output logic        full_l,
    output logic        full_r,
    output logic        req,
    output logic        overflow,
    output logic        underrun,
    output logic [7:0]  underrun_cnt,
    output logic [7:0]  overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_LOW  = LW'(THRESH);

    // Index 0 is the left channel and index 1 is the right channel.
    logic [1:0]       under_v;
    logic [1:0]       drop_v;
    logic [1:0]       full_nx;
    logic [1:0]       low_nx;
    logic [1:0][15:0] out_word;

    for (genvar g = 0; g < 2; g++) begin : g_chan
        localparam logic CH = 1'(g);

        logic [15:0]   mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [LW-1:0] level;
        logic [LW-1:0] level_next;
        logic [15:0]   last_word;
        logic [15:0]   head;
        logic          wr_hit;
        logic          pop_req;
        logic          empty;
        logic          full_now;
        logic          do_pop;
        logic          do_wr;

        // NOTE: every signal is assigned on every pass, so no latch is inferred.
        always_comb begin
            wr_hit     = wr_stb && (wr_right == CH);
            pop_req    = load && (dac_leftright != CH);
            empty      = (level == '0);
            full_now   = (level == LVL_FULL);
            do_pop     = pop_req && !empty;
            // A full FIFO still takes a write when a pop frees a slot in the same cycle.
            do_wr      = wr_hit && (!full_now || do_pop);
            level_next = level + LW'(do_wr) - LW'(do_pop);
            head       = mem[rd_ptr];
        end

        assign under_v[g]  = pop_req && empty;
        assign drop_v[g]   = wr_hit && full_now && !do_pop;
        assign full_nx[g]  = (level_next == LVL_FULL);
        assign low_nx[g]   = (level_next <= LVL_LOW);
        assign out_word[g] = do_pop ? (mute ? 16'h0000 : head)
                                    : ((hold_last && !mute) ? last_word : 16'h0000);

        // NOTE: state registers use non-blocking assignments so that every block reads pre-edge values.
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                last_word <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    last_word <= head;
                end
                level <= level_next;
            end
        end

        // NOTE: sample storage has no reset; the reset pointers and level make stale entries unreachable.
        always_ff @(posedge clock) begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
            end
        end
    end

    function automatic logic [7:0] bump(input logic [7:0] cnt, input logic inc, input logic clr);
        if (clr) begin
            return 8'd0;
        end
        if (inc && (cnt != 8'hFF)) begin
            return cnt + 8'd1;
        end
        return cnt;
    endfunction

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dac_datain   <= '0;
            full_l       <= 1'b0;
            full_r       <= 1'b0;
            req          <= 1'b1;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (load) begin
                dac_datain <= out_word[~dac_leftright];
            end
            full_l       <= full_nx[0];
            full_r       <= full_nx[1];
            req          <= |low_nx;
            overflow     <= |drop_v;
            underrun     <= |under_v;
            underrun_cnt <= bump(underrun_cnt, |under_v, cnt_clr);
            overflow_cnt <= bump(overflow_cnt, |drop_v, cnt_clr);
        end
    end

endmodule

// File: tb/tb_sound_dac_sched.sv
// Self-checking bench for sound_dac_sched. It uses a queue model of both FIFOs and a scoreboard
// of the words that dac_datain is expected to carry.
module tb_sound_dac_sched;

    localparam int DEPTH  = 4;
    localparam int THRESH = 1;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic        dac_leftright = 1'b0;
    logic        wr_stb = 1'b0;
    logic        wr_right = 1'b0;
    logic [15:0] wr_data = '0;
    logic        mute = 1'b0;
    logic        hold_last = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] dac_datain;
    logic        full_l;
    logic        full_r;
    logic        req;
    logic        overflow;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overflow_cnt;

    sound_dac_sched #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .load          (load),
        .dac_leftright (dac_leftright),
        .wr_stb        (wr_stb),
        .wr_right      (wr_right),
        .wr_data       (wr_data),
        .mute          (mute),
        .hold_last     (hold_last),
        .cnt_clr       (cnt_clr),
        .dac_datain    (dac_datain),
        .full_l        (full_l),
        .full_r        (full_r),
        .req           (req),
        .overflow      (overflow),
        .underrun      (underrun),
        .underrun_cnt  (underrun_cnt),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    logic [15:0] sb[$];
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;
    int          exp_ucnt = 0;
    int          exp_ocnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dac_datain"}, dac_datain, 32'h0);
        check({tag, " req"}, req, 32'h1);
        check({tag, " full_l"}, full_l, 32'h0);
        check({tag, " full_r"}, full_r, 32'h0);
        check({tag, " overflow"}, overflow, 32'h0);
        check({tag, " underrun"}, underrun, 32'h0);
        check({tag, " underrun_cnt"}, underrun_cnt, 32'h0);
        check({tag, " overflow_cnt"}, overflow_cnt, 32'h0);
    endtask

    // One clock of stimulus. The model updates first, then the DUT outputs are compared 1 ns after the edge.
    task automatic step(input bit ld, input bit lr, input bit wr, input bit wrr, input logic [15:0] d);
        int          lvl_l;
        int          lvl_r;
        int          lvl;
        bit          exp_under;
        bit          exp_over;
        bit          popped;
        logic [15:0] head;
        logic [15:0] word;
        exp_under = 1'b0;
        exp_over  = 1'b0;
        popped    = 1'b0;
        word      = '0;
        lvl_l     = q_l.size();
        lvl_r     = q_r.size();
        if (ld) begin
            if (!lr) begin
                if (lvl_r > 0) begin
                    head   = q_r.pop_front();
                    last_r = head;
                    word   = mute ? 16'h0000 : head;
                    popped = 1'b1;
                end else begin
                    exp_under = 1'b1;
                    word      = (hold_last && !mute) ? last_r : 16'h0000;
                end
            end else begin
                if (lvl_l > 0) begin
                    head   = q_l.pop_front();
                    last_l = head;
                    word   = mute ? 16'h0000 : head;
                    popped = 1'b1;
                end else begin
                    exp_under = 1'b1;
                    word      = (hold_last && !mute) ? last_l : 16'h0000;
                end
            end
            sb.push_back(word);
        end
        if (wr) begin
            lvl = wrr ? lvl_r : lvl_l;
            if (lvl < DEPTH || (popped && (wrr == !lr))) begin
                if (wrr) q_r.push_back(d);
                else     q_l.push_back(d);
            end else begin
                exp_over = 1'b1;
            end
        end
        if (cnt_clr) begin
            exp_ucnt = 0;
            exp_ocnt = 0;
        end else begin
            if (exp_under && exp_ucnt < 255) exp_ucnt++;
            if (exp_over && exp_ocnt < 255) exp_ocnt++;
        end

        load          = ld;
        dac_leftright = lr;
        wr_stb        = wr;
        wr_right      = wrr;
        wr_data       = d;
        @(posedge clock);
        #1;
        load   = 1'b0;
        wr_stb = 1'b0;

        if (ld) check("dac_datain", dac_datain, sb.pop_front());
        check("underrun", underrun, exp_under);
        check("overflow", overflow, exp_over);
        check("underrun_cnt", underrun_cnt, exp_ucnt);
        check("overflow_cnt", overflow_cnt, exp_ocnt);
        check("full_l", full_l, q_l.size() == DEPTH);
        check("full_r", full_r, q_r.size() == DEPTH);
        check("req", req, (q_l.size() <= THRESH) || (q_r.size() <= THRESH));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        @(posedge clock);
        @(posedge clock);
        #1 rst_n = 1'b1;

        // Reset with no writes: four underruns that output zeros
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        check("ucnt after 4 underruns", underrun_cnt, 32'd4);

        // Normal order
        step(0, 0, 1, 0, 16'h1234);
        step(0, 0, 1, 1, 16'h8001);
        step(0, 0, 1, 0, 16'h7FFF);
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(1, 1, 0, 0, 16'h0);

        // Hold-last and mute
        hold_last = 1'b1;
        step(0, 0, 1, 1, 16'h5555);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        mute = 1'b1;
        step(0, 0, 1, 1, 16'h1111);
        step(1, 0, 0, 0, 16'h0);
        mute = 1'b0;
        step(1, 0, 0, 0, 16'h0);
        hold_last = 1'b0;

        // Full and overflow, then simultaneous write and pop cases
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'hA000 + 16'(i));
        check("ocnt after drop", overflow_cnt, 32'd1);
        step(1, 1, 1, 0, 16'hB000);
        step(1, 1, 1, 1, 16'hC000);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 1, 1, 16'hD000);
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 16'h0);

        // Saturation and clear
        for (int i = 0; i < 300; i++) step(1, (i % 2) == 1, 0, 0, 16'h0);
        check("ucnt saturated", underrun_cnt, 32'd255);
        cnt_clr = 1'b1;
        step(1, 1, 0, 0, 16'h0);
        cnt_clr = 1'b0;
        check("ucnt cleared", underrun_cnt, 32'd0);

        // Reset mid-stream
        step(0, 0, 1, 0, 16'hABCD);
        step(1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'h0100 + 16'(i));
        hold_last = 1'b1;
        rst_n = 1'b0;
        #1 check_reset_outputs("mid-stream");
        q_l.delete();
        q_r.delete();
        sb.delete();
        last_l   = '0;
        last_r   = '0;
        exp_ucnt = 0;
        exp_ocnt = 0;
        @(posedge clock);
        #1 rst_n = 1'b1;
        step(1, 1, 0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sound_dac_sched.md
# sound_dac_sched

Stereo sample scheduler between the sample sources (Z80 port writes / mixer) and the `sound_dac` serializer. Buffers left and right samples in two small FIFOs. On each serializer `load` strobe it presents the next word for the opposite channel on the serializer's 16-bit `datain` bus. It handles underrun (zero or hold-last), mute and overflow, and gives the source a refill request plus status counters.

## Interface
- `DEPTH`, 4: entries per channel FIFO; power of two, 2..16.
- `THRESH`, 1: `req` is asserted while either channel level is <= `THRESH`.
- `clock`  in  1  system clock, 24 MHz, same as the serializer.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  one-cycle pulse from the serializer: a word was just loaded.
- `dac_leftright`  in  1  serializer channel flag (0 left, 1 right). Sampled only when `load`=1.
- `wr_stb`  in  1  one-cycle write strobe from the source.
- `wr_right`  in  1  channel of the write (0 left, 1 right).
- `wr_data`  in  16  sample, two's complement.
- `mute`  in  1  level: output zeros, FIFOs still consumed.
- `hold_last`  in  1  underrun policy: 1 repeats the last word of that channel, 0 outputs 0.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `dac_datain`  out  16  word to the serializer `datain`; registered.
- `full_l`, `full_r`  out  1 each  channel FIFO full.
- `req`  out  1  refill request; registered.
- `overflow`  out  1  one-cycle pulse: a write was dropped.
- `underrun`  out  1  one-cycle pulse: a pop found its FIFO empty.
- `underrun_cnt`  out  8  saturating underrun count.
- `overflow_cnt`  out  8  saturating overflow count.

## Operation
- **FIFOs.** Two independent FIFOs (left, right), each `DEPTH` deep. Each has a write pointer, a read pointer and a level counter of width log2(`DEPTH`)+1. Pointers wrap modulo `DEPTH`.
- **Write.**
  - A `wr_stb` cycle writes `wr_data` into the FIFO selected by `wr_right` if that FIFO is not full.
  - If the FIFO is full, the write is dropped: `overflow` pulses and `overflow_cnt` increments.
- **Pop trigger.** On a `load` cycle, the target channel is `~dac_leftright`: the serializer is now shifting channel `dac_leftright`, and the next load carries the other channel.
- **Pop, FIFO non-empty.**
  - Pop the head of the target FIFO.
  - `dac_datain` is set to 0 if `mute`=1, otherwise to the head value.
  - The head value (not the muted value) is stored as the channel's last word.
- **Pop, FIFO empty.**
  - No pop; `underrun` pulses and `underrun_cnt` increments.
  - `dac_datain` is set to the channel's last word if `hold_last`=1 and `mute`=0, otherwise to 0.
- **Simultaneous write and pop, same channel.**
  - Both take effect. The level changes by 0 when the FIFO is non-empty.
  - If the FIFO is empty, the write is stored and the pop is an underrun; the new word is not bypassed.
  - If the FIFO is full, the write is accepted because a slot frees in the same cycle.
- **Counters.** Both 8-bit counters saturate at 255. `cnt_clr` zeroes them; if `cnt_clr` and an increment occur together, `cnt_clr` wins.
- **`req`.** `req` = (level_l <= `THRESH`) | (level_r <= `THRESH`), registered.
- **Reset.** While `rst_n`=0:
  - `dac_datain`=0, `req`=1, `full_l`=`full_r`=0, `overflow`=`underrun`=0, both counters 0.
  - Pointers, levels and last-word registers are 0.
  - Reset asserted mid-stream discards buffered samples immediately.

## Timing
- `dac_datain` updates on the clock edge after the `load` cycle and then stays constant until the next `load`, i.e. for 320 clocks at the serializer's 1/5 and 64-step cadence. The serializer samples it 319 cycles later, so no combinational path exists from FIFO to `datain`.
- `underrun` and `overflow` are registered, asserting one cycle after the causing `load` / `wr_stb`.
- `full_l` and `full_r` are registered from the level counters and reflect a write or pop on the next cycle.
- A source honouring `full_*` never overflows.
- `req` lags level changes by one cycle.
- Back-to-back `wr_stb` on consecutive cycles is supported; the sustained rate is limited only by the full flags.
- `load` with `wr_stb` in the same cycle on different channels: both are serviced independently.

## Test plan
- **Reset with no writes.** Reset, then 4 loads alternating `dac_leftright` 1,0,1,0 with no writes, `hold_last`=0 → `dac_datain`=0x0000 throughout, 4 `underrun` pulses, `underrun_cnt`=4, `req`=1.
- **Normal order.**
  - Write L=0x1234, R=0x8001, L=0x7FFF.
  - `load` with `dac_leftright`=1 → next cycle `dac_datain`=0x1234.
  - `load` with `dac_leftright`=0 → `dac_datain`=0x8001.
  - `load` with `dac_leftright`=1 → `dac_datain`=0x7FFF.
- **Hold-last and mute.**
  - `hold_last`=1; R FIFO holds 0x5555 only; pop R twice → 0x5555 both times, one `underrun`.
  - Set `mute`=1, write R=0x1111, pop R → 0x0000, and the R FIFO is empty afterwards.
- **Full and overflow.**
  - `DEPTH`=4: write 5 left samples back-to-back → `full_l`=1 after the 4th, 5th dropped, `overflow` pulses once, `overflow_cnt`=1.
  - A same-cycle pop-L plus write-L while full → accepted, level stays 4.
- **Saturation and clear.** 300 underruns → `underrun_cnt`=255. Then `cnt_clr` coinciding with an underrun → 0.
- **Reset mid-stream.** Assert `rst_n`=0 with 3 samples buffered and `dac_datain`=0xABCD → outputs return to reset values asynchronously. After release, the first `load` gives an underrun with output 0.
